nco_sweep_ctrl: RTL
===================

# nco_sweep_ctrl

Sequencing controller for the NCO in the `pll_clock` domain. It generates the NCO clock enable from a programmable prescaler and steps the NCO frequency word through a configured sweep: one-shot ramp, repeating sawtooth or triangle. The sweep dwells for a fixed number of enabled NCO ticks at each frequency. The block replaces the constant frequency word and tied-high `clk_en` at the top level. Software or a test FSM drives it with a start/abort handshake and static configuration.

## Interface

- FW_WIDTH, 8, frequency-word width (matches NCO phase-increment input)
- DWELL_WIDTH, 16, dwell counter width
- DIV_WIDTH, 25, prescaler width
- pll_clock  in  1  sole clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  sweep request; sampled only in IDLE
- abort  in  1  terminate sweep; priority over start
- cfg_start_fw  in  FW_WIDTH  first frequency word
- cfg_stop_fw  in  FW_WIDTH  upper bound (inclusive)
- cfg_step  in  FW_WIDTH  increment per step
- cfg_dwell  in  DWELL_WIDTH  enabled NCO ticks per step; 0 treated as 1
- cfg_div  in  DIV_WIDTH  nco_clk_en asserted once per cfg_div+1 cycles
- cfg_mode  in  2  0 one-shot up, 1 sawtooth, 2 triangle, 3 = one-shot
- nco_clk_en  out  1  NCO clock enable
- nco_fw  out  FW_WIDTH  NCO frequency word
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at one-shot completion
- step_strobe  out  1  one-cycle pulse whenever nco_fw is loaded

## Operation

- States: IDLE, RUN_UP, RUN_DOWN. All outputs are registered.
- Reset: state IDLE. nco_clk_en, nco_fw, busy, done and step_strobe are all 0.
- Config is latched on an accepted start. Config changes during a run are ignored.
- IDLE with start=1 and abort=0:
  - latch config, load nco_fw=cfg_start_fw, pulse step_strobe
  - clear prescaler and dwell counters, enter RUN_UP
- Prescaler runs freely throughout RUN_*. It is not reset at steps.
- Dwell counter counts nco_clk_en pulses. Reaching the dwell count triggers a step event and clears the counter.
- Step arithmetic uses FW_WIDTH+1 bits. Results never wrap.
  - RUN_UP: if fw+step <= stop, then fw += step.
  - Otherwise, mode 0/3: end sweep. Mode 1: fw = start. Mode 2: enter RUN_DOWN and fw -= step if fw-step >= start, else hold.
  - RUN_DOWN: if fw-step >= start (no borrow), then fw -= step.
  - Otherwise: enter RUN_UP and fw += step if fw+step <= stop, else hold.
- Every load of nco_fw pulses step_strobe, including a load of the same value.
- End sweep: pulse done, clear busy, return to IDLE. nco_fw holds its last value. nco_clk_en drops to 0.
- abort while busy: IDLE next cycle, busy=0, nco_clk_en=0, no done pulse. nco_fw holds.
- start while busy is ignored. abort in IDLE has no effect.
- cfg_step=0: fw never changes. Mode 0 then never completes and runs until abort.
- cfg_start_fw > cfg_stop_fw: mode 0 dwells once at start, then ends. Mode 1 reloads start on every step.

## Timing

- Start accepted at cycle T:
  - T+1: busy=1, nco_fw=cfg_start_fw, step_strobe=1.
- nco_clk_en high at T+1+div+k·(div+1), for k>=0. div=0 gives continuous enable from T+1.
- Step event at the dwell-th enable pulse, cycle C:
  - C+1: nco_fw updated with step_strobe.
  - The NCO therefore sees exactly dwell enabled ticks per frequency word.
- End sweep at step event C:
  - C+1: done=1, busy=0, nco_clk_en=0 (prescaler pulse suppressed).
- Abort asserted at cycle A: busy=0 and nco_clk_en=0 at A+1.
- rst_n low at any time: all outputs 0 asynchronously. The first start is accepted at the first rising edge after release.

## Test plan

- Reset mid-run: assert rst_n low during RUN_UP -> all outputs 0 immediately; after release, busy stays 0 until start.
- One-shot ramp (mode 0, start=10, stop=16, step=3, dwell=2, div=0), start at T:
  - fw=10 at T+1, 13 at T+3, 16 at T+5
  - nco_clk_en high T+1..T+6
  - T+7: done pulse, busy=0, nco_clk_en=0
  - step_strobe exactly at T+1, T+3, T+5
- Prescaler: div=3, dwell=2 -> nco_clk_en at T+4, T+8, T+12; fw update at T+9.
- Triangle (mode 2, start=2, stop=8, step=3, dwell=1, div=0) -> nco_fw sequence 2,5,8,5,2,5,8, one per cycle; busy stays 1.
- Sawtooth overflow (FW_WIDTH=8, mode 1, start=250, stop=255, step=4, dwell=1) -> 250,254,250,254; never 2.
- Handshake:
  - start pulsed while busy -> no change
  - abort at A -> busy=0 at A+1, no done pulse, nco_fw holds
  - start and abort together in IDLE -> remains IDLE

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sequencing controller for the NCO in the pll_clock domain.
// Generates the NCO clock enable from a programmable prescaler and steps the
// NCO frequency word through a one-shot ramp, sawtooth or triangle sweep,
// dwelling a configured number of enabled ticks on each word.
//
// Ports:
//   pll_clock, rst_n        clock, asynchronous active-low reset
//   start, abort            sweep handshake (abort has priority)
//   cfg_start_fw/stop_fw    sweep bounds (inclusive)
//   cfg_step                frequency increment per step
//   cfg_dwell               enabled ticks per word (0 behaves as 1)
//   cfg_div                 enable once every cfg_div+1 cycles
//   cfg_mode                0/3 one-shot, 1 sawtooth, 2 triangle
//   nco_clk_en, nco_fw      NCO drive (registered)
//   busy, done, step_strobe status (registered)
module nco_sweep_ctrl #(
    parameter int unsigned FW_WIDTH    = 8,
    parameter int unsigned DWELL_WIDTH = 16,
    parameter int unsigned DIV_WIDTH   = 25
) (
    input  logic                   pll_clock,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FW_WIDTH-1:0]    cfg_start_fw,
    input  logic [FW_WIDTH-1:0]    cfg_stop_fw,
    input  logic [FW_WIDTH-1:0]    cfg_step,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic [DIV_WIDTH-1:0]   cfg_div,
    input  logic [1:0]             cfg_mode,
    output logic                   nco_clk_en,
    output logic [FW_WIDTH-1:0]    nco_fw,
    output logic                   busy,
    output logic                   done,
    output logic                   step_strobe
);

    typedef enum logic [1:0] {StIdle, StRunUp, StRunDown} state_t;

    state_t                 r_state, w_state_d;
    logic [FW_WIDTH-1:0]    r_start_fw, r_stop_fw, r_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic [DIV_WIDTH-1:0]   r_div;
    logic [1:0]             r_mode;
    logic [DIV_WIDTH-1:0]   r_presc, w_presc_d, w_presc_inc;
    logic [DWELL_WIDTH-1:0] r_dwell_cnt, w_dwell_cnt_d, w_dwell_last;
    logic                   r_clk_en, w_clk_en_d;
    logic [FW_WIDTH-1:0]    r_fw, w_fw_d;
    logic                   r_busy, w_busy_d;
    logic                   r_done, w_done_d;
    logic                   r_strobe, w_strobe_d;

    logic                   w_accept;
    logic                   w_step_evt;
    logic                   w_end;
    logic [FW_WIDTH:0]      w_up_sum, w_dn_diff;
    logic                   w_up_ok, w_dn_ok;

    assign w_accept = (r_state == StIdle) && start && !abort;

    // One extra bit so that neither direction can wrap around the word range.
    assign w_up_sum  = {1'b0, r_fw} + {1'b0, r_step};
    assign w_dn_diff = {1'b0, r_fw} - {1'b0, r_step};
    assign w_up_ok   = (w_up_sum <= {1'b0, r_stop_fw});
    assign w_dn_ok   = !w_dn_diff[FW_WIDTH] && (w_dn_diff[FW_WIDTH-1:0] >= r_start_fw);

    assign w_dwell_last = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
    assign w_step_evt   = r_clk_en && (r_dwell_cnt == w_dwell_last);
    assign w_presc_inc  = (r_presc == r_div) ? '0 : r_presc + 1'b1;

    always_comb begin
        w_state_d     = r_state;
        w_presc_d     = r_presc;
        w_dwell_cnt_d = r_dwell_cnt;
        w_clk_en_d    = 1'b0;
        w_fw_d        = r_fw;
        w_busy_d      = r_busy;
        w_done_d      = 1'b0;
        w_strobe_d    = 1'b0;
        w_end         = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d     = StRunUp;
                    w_fw_d        = cfg_start_fw;
                    w_strobe_d    = 1'b1;
                    w_presc_d     = '0;
                    w_dwell_cnt_d = '0;
                    w_busy_d      = 1'b1;
                    w_clk_en_d    = (cfg_div == '0);
                end
            end
            StRunUp, StRunDown: begin
                if (abort) begin
                    w_state_d = StIdle;
                    w_busy_d  = 1'b0;
                end else begin
                    // Prescaler free-runs; it is never realigned at a step.
                    w_presc_d  = w_presc_inc;
                    w_clk_en_d = (w_presc_inc == r_div);
                    if (r_clk_en) begin
                        w_dwell_cnt_d = w_step_evt ? '0 : r_dwell_cnt + 1'b1;
                    end
                    if (w_step_evt) begin
                        // Any non-terminal step reloads the word, even when unchanged.
                        w_strobe_d = 1'b1;
                        if (r_state == StRunUp) begin
                            if (w_up_ok) begin
                                w_fw_d = w_up_sum[FW_WIDTH-1:0];
                            end else if (r_mode == 2'd1) begin
                                w_fw_d = r_start_fw;
                            end else if (r_mode == 2'd2) begin
                                w_state_d = StRunDown;
                                if (w_dn_ok) w_fw_d = w_dn_diff[FW_WIDTH-1:0];
                            end else begin
                                w_end = 1'b1;
                            end
                        end else begin
                            if (w_dn_ok) begin
                                w_fw_d = w_dn_diff[FW_WIDTH-1:0];
                            end else begin
                                w_state_d = StRunUp;
                                if (w_up_ok) w_fw_d = w_up_sum[FW_WIDTH-1:0];
                            end
                        end
                    end
                    if (w_end) begin
                        w_state_d  = StIdle;
                        w_busy_d   = 1'b0;
                        w_done_d   = 1'b1;
                        w_clk_en_d = 1'b0;
                        w_strobe_d = 1'b0;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge pll_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_start_fw <= '0;
            r_stop_fw  <= '0;
            r_step     <= '0;
            r_dwell    <= '0;
            r_div      <= '0;
            r_mode     <= '0;
        end else if (w_accept) begin
            r_start_fw <= cfg_start_fw;
            r_stop_fw  <= cfg_stop_fw;
            r_step     <= cfg_step;
            r_dwell    <= cfg_dwell;
            r_div      <= cfg_div;
            r_mode     <= cfg_mode;
        end
    end

    always_ff @(posedge pll_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_presc     <= '0;
            r_dwell_cnt <= '0;
            r_clk_en    <= 1'b0;
            r_fw        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_strobe    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_presc     <= w_presc_d;
            r_dwell_cnt <= w_dwell_cnt_d;
            r_clk_en    <= w_clk_en_d;
            r_fw        <= w_fw_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_strobe    <= w_strobe_d;
        end
    end

    assign nco_clk_en  = r_clk_en;
    assign nco_fw      = r_fw;
    assign busy        = r_busy;
    assign done        = r_done;
    assign step_strobe = r_strobe;

endmodule
